// File: rtl/sbm_pkg.sv
// ---------------------------------------------------------------------------
// sbm_pkg
//   Shared definitions for the digit-serial schoolbook multiplier:
//   - sbm_state_e : control FSM state encoding
//   - ceil_div    : integer ceiling division used to size the digit count
//   - clog2_min1  : counter width helper, never narrower than one bit
// ---------------------------------------------------------------------------
package sbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } sbm_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 32'sd1) / den;
  endfunction

  function automatic int clog2_min1(input int value);
    return (value > 32'sd1) ? $clog2(value) : 32'sd1;
  endfunction

endpackage

// File: rtl/sbm_digit_mac.sv
// ---------------------------------------------------------------------------
// sbm_digit_mac
//   Shift-add unit multiplying the full multiplicand by one digit of the
//   multiplier, RADIX_BITS digit bits per enabled cycle (LSB group first).
//   Owns the partial product and the step counter.
// Ports
//   clk   in  1              clock, rising edge
//   rst   in  1              synchronous active-high reset
//   clr   in  1              clear partial product and step counter
//   en    in  1              perform one shift-add step
//   a     in  SIZEA          multiplicand (held stable by the caller)
//   digit in  DIGIT          current multiplier digit
//   pp    out SIZEA+DIGIT    partial product a * digit (after STEPS steps)
//   last  out 1              current step is the final one of the digit
// ---------------------------------------------------------------------------
module sbm_digit_mac
  import sbm_pkg::*;
#(
  parameter int SIZEA      = 1024,
  parameter int DIGIT      = 256,
  parameter int RADIX_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [SIZEA-1:0]       a,
  input  logic [DIGIT-1:0]       digit,
  output logic [SIZEA+DIGIT-1:0] pp,
  output logic                   last
);

  localparam int STEPS = DIGIT / RADIX_BITS;
  localparam int SCW   = clog2_min1(STEPS);
  localparam int PPW   = SIZEA + DIGIT;
  localparam logic [SCW-1:0] STEP_LAST = SCW'(STEPS - 32'sd1);

  logic [SCW-1:0]        step_r;
  logic [PPW-1:0]        pp_r;
  logic [RADIX_BITS-1:0] slice_s;
  logic [PPW-1:0]        term_s;
  logic                  last_s;

  // Current radix group of the digit and its weighted contribution to pp.
  // The true product a*digit fits in PPW bits, so the sum never overflows.
  always_comb begin
    slice_s = digit[int'(step_r)*RADIX_BITS +: RADIX_BITS];
    term_s  = (PPW'(a) * PPW'(slice_s)) << (int'(step_r) * RADIX_BITS);
    last_s  = (step_r == STEP_LAST);
  end

  // Partial product accumulation and step counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_r <= '0;
      pp_r   <= '0;
    end else if (clr) begin
      step_r <= '0;
      pp_r   <= '0;
    end else if (en) begin
      pp_r   <= pp_r + term_s;
      step_r <= last_s ? '0 : step_r + SCW'(1'b1);
    end
  end

  assign pp   = pp_r;
  assign last = last_s;

endmodule

// File: rtl/sbm_digit_serial_mult.sv
// ---------------------------------------------------------------------------
// sbm_digit_serial_mult
//   Digit-serial schoolbook multiplier c = a * b. b is split into DIGITS
//   digits of DIGIT bits (last digit zero-padded); each digit is multiplied
//   by a in sbm_digit_mac and added into the accumulator at offset k*DIGIT.
//   Optional zero-digit skip bypasses the multiply phase for all-zero digits.
// Ports
//   clk   in  1            clock, rising edge
//   rst   in  1            synchronous active-high reset (aborts operation)
//   start in  1            request, sampled only while idle
//   a     in  SIZEA        multiplicand, latched on accepted start
//   b     in  SIZEB        multiplier, latched on accepted start
//   busy  out 1            high from the cycle after accept through DONE
//   done  out 1            one-cycle pulse, c valid in the same cycle
//   c     out SIZEA+SIZEB  product, held until the next done
// ---------------------------------------------------------------------------
module sbm_digit_serial_mult
  import sbm_pkg::*;
#(
  parameter int SIZEA            = 1024,
  parameter int SIZEB            = 1024,
  parameter int DIGIT            = 256,
  parameter int RADIX_BITS       = 1,
  parameter int SKIP_ZERO_DIGITS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SIZEA-1:0]       a,
  input  logic [SIZEB-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [SIZEA+SIZEB-1:0] c
);

  localparam int DIGITS  = ceil_div(SIZEB, DIGIT);
  localparam int STEPS   = DIGIT / RADIX_BITS;
  localparam int DCW     = clog2_min1(DIGITS);
  localparam int PPW     = SIZEA + DIGIT;
  localparam int ACCW    = SIZEA + SIZEB;
  localparam int BPW     = DIGITS * DIGIT;
  localparam bit SKIP_EN = (SKIP_ZERO_DIGITS != 32'sd0);
  localparam logic [DCW-1:0] DIG_LAST = DCW'(DIGITS - 32'sd1);

  if ((DIGIT % RADIX_BITS) != 32'sd0) begin : g_radix_check
    $error("sbm_digit_serial_mult: RADIX_BITS must divide DIGIT");
  end

  sbm_state_e        state_r;
  sbm_state_e        state_nxt_s;
  logic [SIZEA-1:0]  a_r;
  logic [BPW-1:0]    b_pad_r;
  logic [ACCW-1:0]   acc_r;
  logic [DCW-1:0]    digit_r;
  logic [ACCW-1:0]   c_r;
  logic              done_r;
  logic              busy_r;

  logic [BPW-1:0]    b_pad_in_s;
  logic              in_dig0_zero_s;
  logic              digit_last_s;
  logic [DCW-1:0]    digit_inc_s;
  logic              next_dig_zero_s;
  logic [DIGIT-1:0]  cur_digit_s;
  logic [PPW-1:0]    pp_s;
  logic              mac_last_s;
  logic              mac_clr_s;
  logic              mac_en_s;
  logic [ACCW-1:0]   acc_add_s;

  // Digit selection and offset alignment. Bits above SIZEB in the padded
  // top digit are zero because b is zero-extended when latched. digit_inc_s
  // saturates so the look-ahead select never leaves the padded operand.
  always_comb begin
    b_pad_in_s      = BPW'(b);
    in_dig0_zero_s  = (b_pad_in_s[DIGIT-1:0] == {DIGIT{1'b0}});
    digit_last_s    = (digit_r == DIG_LAST);
    digit_inc_s     = digit_last_s ? digit_r : digit_r + DCW'(1'b1);
    next_dig_zero_s = (b_pad_r[int'(digit_inc_s)*DIGIT +: DIGIT] == {DIGIT{1'b0}});
    cur_digit_s     = b_pad_r[int'(digit_r)*DIGIT +: DIGIT];
    acc_add_s       = ACCW'(pp_s) << (int'(digit_r) * DIGIT);
  end

  // Next-state logic and shift-add unit control.
  always_comb begin
    state_nxt_s = state_r;
    mac_clr_s   = 1'b0;
    mac_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mac_clr_s = 1'b1;
          if (SKIP_EN && in_dig0_zero_s) begin
            state_nxt_s = ST_ACC;
          end else begin
            state_nxt_s = ST_MUL;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        mac_en_s = 1'b1;
        if (mac_last_s) begin
          state_nxt_s = ST_ACC;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_ACC: begin
        // pp is consumed into acc this cycle and cleared for the next digit.
        mac_clr_s = 1'b1;
        if (digit_last_s) begin
          state_nxt_s = ST_DONE;
        end else if (SKIP_EN && next_dig_zero_s) begin
          state_nxt_s = ST_ACC;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latching, offset accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_pad_r <= '0;
      acc_r   <= '0;
      digit_r <= '0;
      c_r     <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= a;
            b_pad_r <= b_pad_in_s;
            acc_r   <= '0;
            digit_r <= '0;
          end
        end
        ST_ACC: begin
          acc_r   <= acc_r + acc_add_s;
          digit_r <= digit_inc_s;
        end
        ST_DONE: begin
          c_r    <= acc_r;
          done_r <= 1'b1;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  sbm_digit_mac #(
    .SIZEA      (SIZEA),
    .DIGIT      (DIGIT),
    .RADIX_BITS (RADIX_BITS)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr_s),
    .en    (mac_en_s),
    .a     (a_r),
    .digit (cur_digit_s),
    .pp    (pp_s),
    .last  (mac_last_s)
  );

  assign busy = busy_r;
  assign done = done_r;
  assign c    = c_r;

endmodule

// File: tb/tb_sbm_digit_serial_mult.sv
// ---------------------------------------------------------------------------
// tb_sbm_digit_serial_mult
//   Self-checking bench for sbm_digit_serial_mult. Three instances:
//   u_dut0 : 16x16, DIGIT 8, RADIX 2, no skip   (latency 11)
//   u_dut1 : same geometry with zero-digit skip
//   u_dut2 : 16x20, DIGIT 8, RADIX 2, skip       (padded top digit)
//   Expected products are queued when an operation is launched and popped
//   when the matching done pulse is observed.
// ---------------------------------------------------------------------------
module tb_sbm_digit_serial_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1, start2;
  logic [15:0] a0, b0, a1, b1, a2;
  logic [19:0] b2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [31:0] c0, c1;
  logic [35:0] c2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  sbm_digit_serial_mult #(.SIZEA(16), .SIZEB(16), .DIGIT(8), .RADIX_BITS(2), .SKIP_ZERO_DIGITS(0))
    u_dut0 (.clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .busy(busy0), .done(done0), .c(c0));
  sbm_digit_serial_mult #(.SIZEA(16), .SIZEB(16), .DIGIT(8), .RADIX_BITS(2), .SKIP_ZERO_DIGITS(1))
    u_dut1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .busy(busy1), .done(done1), .c(c1));
  sbm_digit_serial_mult #(.SIZEA(16), .SIZEB(20), .DIGIT(8), .RADIX_BITS(2), .SKIP_ZERO_DIGITS(1))
    u_dut2 (.clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .busy(busy2), .done(done2), .c(c2));

  function automatic logic get_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [63:0] get_c(input int which);
    case (which)
      0:       return {32'd0, c0};
      1:       return {32'd0, c1};
      default: return {28'd0, c2};
    endcase
  endfunction

  function automatic logic [63:0] pop_exp();
    logic [63:0] v;
    v = 64'bx;
    if (exp_q.size() > 0) v = exp_q.pop_front();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse (accepted at the next edge) and queue its result.
  task automatic start_op(input int which, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] expv);
    case (which)
      0:       begin a0 = av[15:0]; b0 = bv[15:0]; start0 = 1'b1; end
      1:       begin a1 = av[15:0]; b1 = bv[15:0]; start1 = 1'b1; end
      default: begin a2 = av[15:0]; b2 = bv[19:0]; start2 = 1'b1; end
    endcase
    exp_q.push_back(expv);
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Count edges until done is seen; -1 when the budget expires.
  task automatic wait_done(input int which, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= 60 && !found; i++) begin
      tick();
      if (get_done(which)) begin
        found = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    a0 = 16'd0; b0 = 16'd0; a1 = 16'd0; b1 = 16'd0; a2 = 16'd0; b2 = 20'd0;
    repeat (3) tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (c0 !== 32'd0) begin errors++; $display("FAIL reset_c: got %h expected 0", c0); end
    rst = 1'b0;
    tick();
  endtask

  // Fixed vectors on the non-skip and skip instances.
  task automatic test_vectors();
    int which_t[7] = '{0, 0, 0, 1, 1, 1, 1};
    logic [15:0] a_t[7] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h00FF, 16'h00FF, 16'h1234, 16'h1234};
    logic [15:0] b_t[7] = '{16'h5678, 16'hFFFF, 16'hABCD, 16'h0003, 16'h0300, 16'h0000, 16'h5678};
    logic [63:0] e_t[7] = '{64'h0626_0060, 64'hFFFE_0001, 64'h0, 64'h2FD, 64'h2_FD00, 64'h0, 64'h0626_0060};
    int          l_t[7] = '{11, 11, 11, 7, 7, 3, 11};
    int n;
    logic [63:0] e;
    for (int k = 0; k < 7; k++) begin
      start_op(which_t[k], {48'd0, a_t[k]}, {48'd0, b_t[k]}, e_t[k]);
      checks++;
      if (get_busy(which_t[k]) !== 1'b1) begin
        errors++; $display("FAIL vec%0d_busy: got %b expected 1", k, get_busy(which_t[k]));
      end
      wait_done(which_t[k], n);
      checks++;
      if (n != l_t[k]) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", k, n, l_t[k]); end
      e = pop_exp();
      checks++;
      if (get_c(which_t[k]) !== e) begin
        errors++; $display("FAIL vec%0d_c: got %h expected %h", k, get_c(which_t[k]), e);
      end
      tick();
      checks++;
      if (get_done(which_t[k]) !== 1'b0) begin errors++; $display("FAIL vec%0d_done_width: done still high", k); end
    end
  endtask

  // start re-pulse with new operands while busy must not disturb the operation.
  task automatic test_restart_ignored();
    int n;
    logic [63:0] e;
    start_op(0, 64'hBEEF, 64'h0102, 64'h00C0_6CDE);
    repeat (3) tick();
    a0 = 16'h1111; b0 = 16'h2222; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done(0, n);
    if (n >= 0) n = n + 4;
    checks++; if (n != 11) begin errors++; $display("FAIL restart_latency: got %0d expected 11", n); end
    e = pop_exp();
    checks++; if ({32'd0, c0} !== e) begin errors++; $display("FAIL restart_c: got %h expected %h", c0, e); end
    tick();
  endtask

  // Reset mid-operation aborts; a fresh start then completes normally.
  task automatic test_rst_mid();
    int n;
    logic [63:0] e;
    start_op(0, 64'h1357, 64'h2468, 64'h1357 * 64'h2468);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done0); end
    checks++; if (c0 !== 32'd0) begin errors++; $display("FAIL rstmid_c: got %h expected 0", c0); end
    rst = 1'b0;
    e = pop_exp();
    tick();
    start_op(0, 64'h00A5, 64'h5A00, 64'h00A5 * 64'h5A00);
    wait_done(0, n);
    checks++; if (n != 11) begin errors++; $display("FAIL rstmid_latency: got %0d expected 11", n); end
    e = pop_exp();
    checks++; if ({32'd0, c0} !== e) begin errors++; $display("FAIL rstmid_c2: got %h expected %h", c0, e); end
    tick();
  endtask

  // Second start in the done cycle; c must hold the first result meanwhile.
  task automatic test_back_to_back();
    int n;
    bit hold_ok;
    bit found;
    logic [63:0] e1, e2;
    start_op(0, 64'h8001, 64'h7FFE, 64'h8001 * 64'h7FFE);
    wait_done(0, n);
    checks++; if (n != 11) begin errors++; $display("FAIL b2b_lat1: got %0d expected 11", n); end
    e1 = pop_exp();
    checks++; if ({32'd0, c0} !== e1) begin errors++; $display("FAIL b2b_c1: got %h expected %h", c0, e1); end
    start_op(0, 64'h0F0F, 64'hC3C3, 64'h0F0F * 64'hC3C3);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL b2b_done_width: done still high"); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy0); end
    hold_ok = 1'b1;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= 60 && !found; i++) begin
      tick();
      if (done0) begin
        found = 1'b1;
        n = i;
      end else if ({32'd0, c0} !== e1) begin
        hold_ok = 1'b0;
      end
    end
    checks++; if (!hold_ok) begin errors++; $display("FAIL b2b_hold: c changed before second done"); end
    checks++; if (n != 11) begin errors++; $display("FAIL b2b_lat2: got %0d expected 11", n); end
    e2 = pop_exp();
    checks++; if ({32'd0, c0} !== e2) begin errors++; $display("FAIL b2b_c2: got %h expected %h", c0, e2); end
    tick();
  endtask

  // Random regression on the plain instance and on the padded skip instance.
  task automatic test_random();
    int n;
    int z;
    int exp_lat;
    logic [63:0] av, bv, e;
    logic [2:0] m;
    for (int k = 0; k < 10; k++) begin
      av = {48'd0, 16'($urandom())};
      bv = {48'd0, 16'($urandom())};
      start_op(0, av, bv, av * bv);
      wait_done(0, n);
      checks++; if (n != 11) begin errors++; $display("FAIL rnd0_%0d_latency: got %0d expected 11", k, n); end
      e = pop_exp();
      checks++; if ({32'd0, c0} !== e) begin errors++; $display("FAIL rnd0_%0d_c: got %h expected %h", k, c0, e); end
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 0) begin
        av = 64'hFFFF;
        bv = 64'hF_FFFF;
      end else begin
        av = {48'd0, 16'($urandom())};
        bv = {44'd0, 20'($urandom())};
        m = 3'($urandom_range(0, 7));
        if (m[0]) bv[7:0] = 8'd0;
        if (m[1]) bv[15:8] = 8'd0;
        if (m[2]) bv[19:16] = 4'd0;
      end
      z = 0;
      if (bv[7:0] == 8'd0) z++;
      if (bv[15:8] == 8'd0) z++;
      if (bv[19:16] == 4'd0) z++;
      exp_lat = 16 - 4 * z;
      start_op(2, av, bv, av * bv);
      wait_done(2, n);
      checks++;
      if (n != exp_lat) begin errors++; $display("FAIL rnd2_%0d_latency: got %0d expected %0d", k, n, exp_lat); end
      e = pop_exp();
      checks++; if ({28'd0, c2} !== e) begin errors++; $display("FAIL rnd2_%0d_c: got %h expected %h", k, c2, e); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_restart_ignored();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
